// File: rtl/rr_multi_grant_scheduler.sv
// Round-robin scheduler issuing up to GRANT_NUM grants per cycle from REQ_NUM requesters.
// Define RR_SCHED_GRANT_COUNT_EN to add the grant_count output (running total of accepted grants).
module rr_multi_grant_scheduler #(
  parameter int REQ_NUM   = 8,
  parameter int GRANT_NUM = 2
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [REQ_NUM-1:0]                          req,
  input  logic                                        flush,
  input  logic                                        grant_ready,
  output logic [GRANT_NUM-1:0]                        grant_valid,
  output logic [GRANT_NUM-1:0][$clog2(REQ_NUM)-1:0]   grant_id
`ifdef RR_SCHED_GRANT_COUNT_EN
  ,
  output logic [31:0]                                 grant_count
`endif
);

  localparam int IDW = $clog2(REQ_NUM);

  logic [IDW-1:0]                  ptr_reg;
  logic [IDW-1:0]                  ptr_next;
  logic [REQ_NUM-1:0]              held_mask;
  logic [REQ_NUM-1:0]              eff_req;
  logic [REQ_NUM-1:0]              rot_req;
  logic [REQ_NUM-1:0]              remaining;
  logic                            found;
  logic [GRANT_NUM-1:0]            pick_valid;
  logic [GRANT_NUM-1:0][IDW-1:0]   pick_id;
  logic                            load;

  // Requesters currently sitting in an output slot must not be picked again.
  always_comb begin
    held_mask = '0;
    for (int g = 0; g < GRANT_NUM; g++) begin
      if (grant_valid[g]) begin
        held_mask[grant_id[g]] = 1'b1;
      end
    end
  end

  assign eff_req = req & ~held_mask;

  // Rotate so bit 0 of rot_req corresponds to requester ptr_reg.
  always_comb begin
    rot_req = '0;
    for (int j = 0; j < REQ_NUM; j++) begin
      rot_req[j] = eff_req[ptr_reg + IDW'(j)];
    end
  end

  always_comb begin
    remaining  = rot_req;
    found      = 1'b0;
    pick_valid = '0;
    pick_id    = '0;
    ptr_next   = ptr_reg;
    for (int g = 0; g < GRANT_NUM; g++) begin
      found = 1'b0;
      for (int j = 0; j < REQ_NUM; j++) begin
        if (!found && remaining[j]) begin
          found         = 1'b1;
          remaining[j]  = 1'b0;
          pick_valid[g] = 1'b1;
          pick_id[g]    = ptr_reg + IDW'(j);
          ptr_next      = ptr_reg + IDW'(j + 1);
        end
      end
    end
  end

  assign load = !flush && ((grant_valid == '0) || grant_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg     <= '0;
      grant_valid <= '0;
      grant_id    <= '0;
    end else if (flush) begin
      grant_valid <= '0;
      grant_id    <= '0;
    end else if (load) begin
      grant_valid <= pick_valid;
      grant_id    <= pick_id;
      if (pick_valid != '0) begin
        ptr_reg <= ptr_next;
      end
    end
  end

`ifdef RR_SCHED_GRANT_COUNT_EN
  logic [31:0] count_reg;
  logic [31:0] accept_num;

  always_comb begin
    accept_num = '0;
    for (int g = 0; g < GRANT_NUM; g++) begin
      accept_num = accept_num + 32'(grant_valid[g]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (grant_ready && !flush) begin
      count_reg <= count_reg + accept_num;
    end
  end

  assign grant_count = count_reg;
`endif

endmodule

// File: doc/rr_multi_grant_scheduler.md
RR_MULTI_GRANT_SCHEDULER -- requirements
Module: rr_multi_grant_scheduler

Interface
REQ-001 Parameter REQ_NUM, default 8, number of requesters; SHALL be a power of two >= 2.
REQ-002 Parameter GRANT_NUM, default 2, maximum grants per cycle; SHALL satisfy 1 <= GRANT_NUM <= REQ_NUM.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port req  input  REQ_NUM  level request per requester.
REQ-006 Port flush  input  1  synchronous discard of held grants.
REQ-007 Port grant_ready  input  1  consumer accepts all valid grant slots this cycle.
REQ-008 Port grant_valid  output  GRANT_NUM  slot g holds a grant.
REQ-009 Port grant_id  output  GRANT_NUM x clog2(REQ_NUM)  granted requester index per slot.

Function
REQ-010 Pick logic SHALL scan eff_req = req & ~held_mask in rotating order ptr, ptr+1, ..., REQ_NUM-1, 0, ..., ptr-1, selecting the first up to GRANT_NUM set bits; held_mask = one-hot OR of grant_id[g] over slots with grant_valid[g]=1.
REQ-011 Picks SHALL fill slots densely from slot 0; unused slots valid=0, id=0.
REQ-012 Load condition: load = !flush && (grant_valid==0 || grant_ready).
REQ-013 On load, output registers SHALL take the picks next cycle; grant latency = 1 cycle from req to grant_valid.
REQ-014 When grant_valid!=0 and grant_ready=0 and flush=0, grant_valid/grant_id SHALL hold stable and ptr SHALL not change.
REQ-015 On load with >=1 pick, ptr SHALL become (last picked index + 1) mod REQ_NUM; with 0 picks ptr unchanged.
REQ-016 A requester SHALL deassert req from the cycle after its grant is accepted; held_mask prevents re-granting it in the acceptance cycle.
REQ-017 flush=1 SHALL clear grant_valid and grant_id to 0 next cycle, leave ptr unchanged, and override grant_ready.
REQ-018 eff_req==0 on load SHALL produce grant_valid=0 next cycle.
REQ-019 A given requester index SHALL never appear in two slots simultaneously.

Reset
REQ-020 rst_n=0 SHALL immediately force ptr=0, grant_valid=0, grant_id=0 (and grant_count=0 when configured), regardless of clk.
REQ-021 Reset mid-operation SHALL discard held grants; first load after release scans from index 0.

Configuration
REQ-022 Macro RR_SCHED_GRANT_COUNT_EN defined: extra output port grant_count  output  32  running total of accepted grants, incremented by popcount(grant_valid) in each cycle with grant_ready=1, flush=0; wraps modulo 2^32.
REQ-023 Macro RR_SCHED_GRANT_COUNT_EN undefined: port grant_count and its counter SHALL not exist; all other behaviour identical.

Verification (REQ_NUM=8, GRANT_NUM=2)
REQ-024 Reset; req=8'b10100110, grant_ready=1 -> next cycle valid=2'b11, ids 1,2, ptr=3; requesters 1,2 drop, req=8'b10100000 -> next cycle ids 5,7, ptr=0.
REQ-025 Grants ids 1,2 held, grant_ready=0 for 5 cycles, req unchanged -> valid/ids stable all 5 cycles, ptr=3, no id repeated after grant_ready=1.
REQ-026 ptr=6, req=8'b01000001 -> ids 6,0 (wrap order), ptr=1.
REQ-027 ptr=0, req=8'b00001000 -> valid=2'b01, grant_id[0]=3, grant_id[1]=0, ptr=4.
REQ-028 Held grants, grant_ready=1 and flush=1 same cycle -> next cycle valid=0, ptr unchanged, grant_count unchanged (if enabled); rst_n pulsed low mid-hold -> outputs 0 immediately, next load from index 0.
REQ-029 RR_SCHED_GRANT_COUNT_EN defined, 10 accepted cycles of 2 grants each -> grant_count=20; random req/ready soak checked against rotating-order software model.
